// File: rtl/tx_aurora_64b66b_framer_if.sv
// Bus bundle between the Aurora 64b/66b transmit framer, its source FIFO and
// the gearbox.
//   master: framer side (pops FIFO, drives blocks and counters)
//   slave : environment side (FIFO, link status, gearbox ready)
interface tx_aurora_64b66b_framer_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HDR_W  = 2;
  localparam int unsigned PAY_W  = 64;
  localparam int unsigned DCNT_W = 16;
  localparam int unsigned PCNT_W = 8;

  logic              link_up;
  logic              out_ready;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_read;
  logic [HDR_W-1:0]  tx_header;
  logic [PAY_W-1:0]  tx_data;
  logic [DCNT_W-1:0] data_block_cnt;
  logic [PCNT_W-1:0] pad_cnt;

  modport master (
    input  link_up, out_ready, fifo_empty, fifo_data,
    output fifo_read, tx_header, tx_data, data_block_cnt, pad_cnt
  );

  modport slave (
    output link_up, out_ready, fifo_empty, fifo_data,
    input  fifo_read, tx_header, tx_data, data_block_cnt, pad_cnt
  );
endinterface

// File: rtl/tx_aurora_64b66b_framer.sv
// Aurora 64b/66b single-lane transmit framer. Packs pairs of 32-bit FWFT FIFO
// words into 66-bit data blocks, fills gaps with idle blocks, inserts periodic
// clock-compensation blocks, pads out lone words after a timeout and
// optionally scrambles the payload (1 + x^39 + x^58).
// Ports:
//   tx_clk    : clock
//   tx_rst_n  : asynchronous active-low reset
//   bus       : link_up, out_ready, fifo_empty, fifo_data in;
//               fifo_read (combinational), tx_header, tx_data,
//               data_block_cnt, pad_cnt out
module tx_aurora_64b66b_framer #(
  parameter int unsigned CC_PERIOD    = 10000,
  parameter int unsigned FLUSH_CYCLES = 64,
  parameter logic [31:0] PAD_WORD     = 32'h0000_0000,
  parameter bit          SCRAMBLE     = 1'b1
) (
  input  logic                              tx_clk,
  input  logic                              tx_rst_n,
  tx_aurora_64b66b_framer_if.master         bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PAY_W  = 64;
  localparam int unsigned SCR_W  = 58;
  localparam int unsigned CC_W   = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int unsigned FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0]       HDR_DATA = 2'b01;
  localparam logic [1:0]       HDR_CTRL = 2'b10;
  localparam logic [PAY_W-1:0] IDLE_BLK = 64'h7800_0000_0000_0000;
  localparam logic [PAY_W-1:0] CC_BLK   = 64'h7880_0000_0000_0000;

  typedef enum logic {ST_EMPTY, ST_HELD} pack_state_e;

  pack_state_e       state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [CC_W-1:0]   cc_q;
  logic [SCR_W-1:0]  scr_q, scr_next;
  logic [1:0]        hdr_q, hdr_d;
  logic [PAY_W-1:0]  data_q, pay_d, scr_pay;
  logic [15:0]       blk_cnt_q;
  logic [7:0]        pad_cnt_q;
  logic              inc_data, inc_pad;
  logic              cc_due, flush_due;

  assign cc_due    = (cc_q == CC_W'(CC_PERIOD - 1));
  assign flush_due = (flush_q == FL_W'(FLUSH_CYCLES - 1));

  // Pop only when a word is actually consumed; blocked while held in reset.
  assign bus.fifo_read = bus.out_ready & bus.link_up & ~bus.fifo_empty & ~cc_due & tx_rst_n;

  assign bus.tx_header      = hdr_q;
  assign bus.tx_data        = data_q;
  assign bus.data_block_cnt = blk_cnt_q;
  assign bus.pad_cnt        = pad_cnt_q;

  // Block selection and packer next state; priority CC > link down > data.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    flush_d  = flush_q;
    hdr_d    = HDR_CTRL;
    pay_d    = IDLE_BLK;
    inc_data = 1'b0;
    inc_pad  = 1'b0;
    if (cc_due) begin
      pay_d = CC_BLK;
    end else if (!bus.link_up) begin
      pay_d = IDLE_BLK;
    end else if (state_q == ST_HELD) begin
      if (!bus.fifo_empty) begin
        hdr_d    = HDR_DATA;
        pay_d    = {hold_q, bus.fifo_data};
        state_d  = ST_EMPTY;
        inc_data = 1'b1;
      end else if (flush_due) begin
        hdr_d    = HDR_DATA;
        pay_d    = {hold_q, PAD_WORD};
        state_d  = ST_EMPTY;
        inc_data = 1'b1;
        inc_pad  = 1'b1;
      end else begin
        flush_d = flush_q + FL_W'(1);
      end
    end else if (!bus.fifo_empty) begin
      hold_d  = bus.fifo_data;
      state_d = ST_HELD;
      flush_d = '0;
    end
  end

  // Bit-serial self-synchronous scrambler unrolled over the 64 payload bits.
  function automatic logic [SCR_W+PAY_W-1:0] scramble(input logic [PAY_W-1:0] din,
                                                      input logic [SCR_W-1:0] s_in);
    logic [SCR_W-1:0] s;
    logic [PAY_W-1:0] dout;
    s    = s_in;
    dout = '0;
    for (int i = 0; i < PAY_W; i++) begin
      dout[i] = din[i] ^ s[38] ^ s[57];
      s       = {s[SCR_W-2:0], dout[i]};
    end
    return {s, dout};
  endfunction

  assign {scr_next, scr_pay} = scramble(pay_d, scr_q);

  // State, counters and output block; everything freezes without out_ready.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q   <= ST_EMPTY;
      hold_q    <= '0;
      flush_q   <= '0;
      cc_q      <= '0;
      scr_q     <= '0;
      hdr_q     <= HDR_CTRL;
      data_q    <= IDLE_BLK;
      blk_cnt_q <= '0;
      pad_cnt_q <= '0;
    end else if (bus.out_ready) begin
      state_q <= state_d;
      hold_q  <= hold_d;
      flush_q <= flush_d;
      cc_q    <= cc_due ? '0 : cc_q + CC_W'(1);
      scr_q   <= SCRAMBLE ? scr_next : scr_q;
      hdr_q   <= hdr_d;
      data_q  <= SCRAMBLE ? scr_pay : pay_d;
      if (inc_data) blk_cnt_q <= blk_cnt_q + 16'd1;
      if (inc_pad && (pad_cnt_q != 8'hFF)) pad_cnt_q <= pad_cnt_q + 8'd1;
    end
  end
endmodule
